// File: rtl/seven_segment_scan_controller.sv
// Binary-to-BCD (double-dabble) converter feeding a four-digit multiplexed
// 7-segment display with optional leading-zero blanking.
module seven_segment_scan_controller #(
    parameter int unsigned CLK_DIV       = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       value_valid,
    input  logic [9:0] value,
    output logic       value_ready,
    output logic       busy,
    output logic       done,
    output logic [3:0] digit_en,
    output logic [6:0] segment
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_COMMIT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [9:0]    r_bin;
    logic [15:0]   r_bcd;
    logic [3:0]    r_iter;
    logic [15:0]   r_disp;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   w_adj;
    logic          w_tick;
    logic [3:0]    w_digit;
    logic          w_blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        value_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                value_ready = 1'b1;
                if (value_valid) begin
                    w_next = S_CONVERT;
                end
            end
            S_CONVERT: begin
                busy = 1'b1;
                if (r_iter == 4'd9) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Add-3 correction applied before each shift.
    always_comb begin
        w_adj = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end else begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_iter <= '0;
            r_disp <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (value_valid) begin
                        r_bin  <= value;
                        r_bcd  <= '0;
                        r_iter <= '0;
                    end
                end
                S_CONVERT: begin
                    {r_bcd, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
                    r_iter         <= r_iter + 4'd1;
                end
                S_COMMIT: begin
                    r_disp <= r_bcd;
                end
                default: ;
            endcase
        end
    end

    assign w_tick = (r_presc == PW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    always_comb begin
        w_digit = r_disp[3:0];
        w_blank = 1'b0;
        case (r_idx)
            2'd0: begin
                w_digit = r_disp[3:0];
            end
            2'd1: begin
                w_digit = r_disp[7:4];
                w_blank = BLANK_LEADING && (r_disp[15:4] == 12'd0);
            end
            2'd2: begin
                w_digit = r_disp[11:8];
                w_blank = BLANK_LEADING && (r_disp[15:8] == 8'd0);
            end
            default: begin
                w_digit = r_disp[15:12];
                w_blank = BLANK_LEADING && (r_disp[15:12] == 4'd0);
            end
        endcase
    end

    assign digit_en = 4'b0001 << r_idx;
    assign segment  = w_blank ? 7'h7F : seg_decode(w_digit);

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for seven_segment_scan_controller with CLK_DIV=4, covering
// both the blanking and non-blanking configurations.
module tb_seven_segment_scan_controller;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'h7F;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_a = 1'b0;
    logic [9:0] value_a = '0;
    logic       ready_a, busy_a, done_a;
    logic [3:0] en_a;
    logic [6:0] seg_a;
    logic       valid_b = 1'b0;
    logic [9:0] value_b = '0;
    logic       ready_b, busy_b, done_b;
    logic [3:0] en_b;
    logic [6:0] seg_b;

    int total = 0;
    int bad   = 0;
    logic [6:0] seen [4];

    always #5 clk = ~clk;

    seven_segment_scan_controller #(.CLK_DIV(4), .BLANK_LEADING(1'b1)) u_dut (
        .clk(clk), .rst(rst), .value_valid(valid_a), .value(value_a),
        .value_ready(ready_a), .busy(busy_a), .done(done_a),
        .digit_en(en_a), .segment(seg_a)
    );

    seven_segment_scan_controller #(.CLK_DIV(4), .BLANK_LEADING(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .value_valid(valid_b), .value(value_b),
        .value_ready(ready_b), .busy(busy_b), .done(done_b),
        .digit_en(en_b), .segment(seg_b)
    );

    function automatic int en_to_idx(input logic [3:0] en);
        case (en)
            4'b0001: en_to_idx = 0;
            4'b0010: en_to_idx = 1;
            4'b0100: en_to_idx = 2;
            4'b1000: en_to_idx = 3;
            default: en_to_idx = -1;
        endcase
    endfunction

    task automatic read_slots(input bit inst);
        logic [3:0] en;
        logic [6:0] sg;
        int         ix;
        for (int i = 0; i < 4; i++) seen[i] = 'x;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            en = inst ? en_b : en_a;
            sg = inst ? seg_b : seg_a;
            total++;
            if (!$onehot(en)) begin
                bad++;
                $display("FAIL digit_en_onehot got=%b exp=one-hot", en);
            end
            ix = en_to_idx(en);
            if (ix >= 0) seen[ix] = sg;
        end
    endtask

    task automatic check_slots(input string name, input bit inst,
                               input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] exp_s [4];
        exp_s[0] = e0; exp_s[1] = e1; exp_s[2] = e2; exp_s[3] = e3;
        read_slots(inst);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (seen[i] !== exp_s[i]) begin
                bad++;
                $display("FAIL %s_slot%0d got=%b exp=%b", name, i, seen[i], exp_s[i]);
            end
        end
    endtask

    task automatic wait_ready(input bit inst);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((inst ? ready_b : ready_a) === 1'b1) break;
        end
        total++;
        if (k == 40) begin
            bad++;
            $display("FAIL wait_ready got=0 exp=1");
        end
    endtask

    task automatic load(input bit inst, input logic [9:0] v);
        int n;
        wait_ready(inst);
        if (inst) begin valid_b = 1'b1; value_b = v; end
        else      begin valid_a = 1'b1; value_a = v; end
        @(posedge clk);
        #1;
        if (inst) begin valid_b = 1'b0; value_b = ~v; end
        else      begin valid_a = 1'b0; value_a = ~v; end
        for (n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) begin
                total++;
                if ((inst ? busy_b : busy_a) !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_after_accept got=%b exp=1", inst ? busy_b : busy_a);
                end
            end
            if ((inst ? done_b : done_a) === 1'b1) break;
        end
        total++;
        if (n != 11) begin
            bad++;
            $display("FAIL done_latency got=%0d exp=11", n);
        end
        @(negedge clk);
        total++;
        if ((inst ? ready_b : ready_a) !== 1'b1 || (inst ? done_b : done_a) !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_done got=%b exp=1", inst ? ready_b : ready_a);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                total++;
                if (ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_ctrl got=%b%b%b exp=100", ready_a, busy_a, done_a);
                end
                total++;
                if (seg_a !== S0) begin
                    bad++;
                    $display("FAIL reset_segment got=%b exp=%b", seg_a, S0);
                end
            end
            total++;
            if (en_a !== ((k == 5) ? 4'b0010 : 4'b0001)) begin
                bad++;
                $display("FAIL reset_scan_k%0d got=%b exp=%b", k, en_a,
                         (k == 5) ? 4'b0010 : 4'b0001);
            end
        end
        check_slots("reset", 1'b0, SB, SB, SB, S0);
    endtask

    task automatic test_load9;
        load(1'b0, 10'd9);
        check_slots("load9", 1'b0, SB, SB, SB, S9);
    endtask

    task automatic test_no_blank;
        load(1'b1, 10'd9);
        check_slots("noblank9", 1'b1, S0, S0, S0, S9);
    endtask

    task automatic test_load1023;
        load(1'b0, 10'd1023);
        check_slots("load1023", 1'b0, S1, S0, S2, S3);
    endtask

    task automatic test_reject_busy;
        logic [6:0] old_s [4];
        int n;
        int ix;
        old_s[0] = S3; old_s[1] = S2; old_s[2] = S0; old_s[3] = S1;
        wait_ready(1'b0);
        valid_a = 1'b1;
        value_a = 10'd999;
        @(posedge clk);
        #1 value_a = 10'd5;
        for (n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                valid_a = 1'b0;
                break;
            end
            total++;
            if (ready_a !== 1'b0) begin
                bad++;
                $display("FAIL ready_while_busy n=%0d got=%b exp=0", n, ready_a);
            end
            if (n == 5) begin
                ix = en_to_idx(en_a);
                total++;
                if (ix < 0 || seg_a !== old_s[ix]) begin
                    bad++;
                    $display("FAIL old_display_kept got=%b exp=old digit", seg_a);
                end
            end
        end
        valid_a = 1'b0;
        total++;
        if (n != 11) begin
            bad++;
            $display("FAIL reject_done_latency got=%0d exp=11", n);
        end
        check_slots("reject999", 1'b0, SB, S9, S9, S9);
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        wait_ready(1'b0);
        valid_a = 1'b1;
        value_a = 10'd99;
        @(posedge clk);
        #1 valid_a = 1'b0;
        for (int n = 1; n <= 5; n++) @(negedge clk);
        total++;
        if (busy_a !== 1'b1) begin
            bad++;
            $display("FAIL busy_before_reset got=%b exp=1", busy_a);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 ||
            en_a !== 4'b0001 || seg_a !== S0) begin
            bad++;
            $display("FAIL reset_mid_state got=%b%b%b_%b_%b exp=100_0001_%b",
                     ready_a, busy_a, done_a, en_a, seg_a, S0);
        end
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done_a === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL reset_mid_done got=%0d exp=0", dones);
        end
        check_slots("reset_mid", 1'b0, SB, SB, SB, S0);
    endtask

    task automatic test_back_to_back;
        wait_ready(1'b0);
        valid_a = 1'b1;
        value_a = 10'd100;
        for (int c = 0; c < 48; c++) begin
            if (c > 0) @(negedge clk);
            total++;
            if (done_a !== ((c % 12) == 11)) begin
                bad++;
                $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done_a, (c % 12) == 11);
            end
            total++;
            if (ready_a !== ((c % 12) == 0)) begin
                bad++;
                $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, ready_a, (c % 12) == 0);
            end
        end
        valid_a = 1'b0;
        check_slots("b2b100", 1'b0, SB, S1, S0, S0);
    endtask

    initial begin
        test_reset();
        test_load9();
        test_no_blank();
        test_load1023();
        test_reject_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
